// File: rtl/syscall_pkg.sv
// syscall_queue shared parameters
// and status-word layout helper.
package syscall_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Overflow flag lives in the MSB
  // of the status readback word.
  function automatic int ovf_bit(
    input int data_w
  );
    return data_w - 1;
  endfunction

endpackage

// File: rtl/syscall_queue_mem.sv
// syscall_queue entry storage:
// 1W/1R register file, async clear.
module syscall_queue_mem
  import syscall_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W =
    $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Clear all slots on reset so the
  // head reads as zero when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/syscall_queue.sv
// Wishbone syscall request queue:
// bus writes enqueue, SYSCTRL pops.
module syscall_queue
  import syscall_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CNT_W =
    $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] WB_ADRi,
  input  logic [DATA_W-1:0] WB_DATi,
  output logic [DATA_W-1:0] WB_DATo,
  input  logic              WB_WEi,
  input  logic              WB_CYCi,
  input  logic              WB_STBi,
  output logic              WB_ACKo,
  input  logic              SYSCALL_pop,
  output logic              SYSCALL_trig,
  output logic [ADDR_W-1:0] SYSCALL_num,
  output logic [DATA_W-1:0] SYSCALL_info,
  output logic [CNT_W-1:0]  SYSCALL_cnt,
  output logic              SYSCALL_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int W     = ADDR_W + DATA_W;
  localparam int OVF   = ovf_bit(DATA_W);

  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic              ovf_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] status;
  logic [W-1:0]      head;

  logic accept;
  logic wr_acc;
  logic rd_acc;
  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;
  logic drop;

  assign accept  = WB_CYCi & WB_STBi
                 & ~ack_q;
  assign wr_acc  = accept & WB_WEi;
  assign rd_acc  = accept & ~WB_WEi;
  assign full    = cnt_q ==
                   CNT_W'(DEPTH);
  assign empty   = cnt_q == '0;
  assign pop_ok  = SYSCALL_pop & ~empty;
  // A pop on a full queue frees the
  // slot the new entry goes into.
  assign push_ok = wr_acc
                 & (~full | SYSCALL_pop);
  assign drop    = wr_acc & full
                 & ~SYSCALL_pop;

  // Status word: ovf in MSB, count
  // in the LSBs, zero in between.
  always_comb begin
    status             = '0;
    status[OVF]        = ovf_q;
    status[CNT_W-1:0]  = cnt_q;
  end

  // One-cycle ack per accepted access,
  // read data latched on reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      if (rd_acc)
        dat_q <= status;
    end
  end

  // Sticky overflow: a drop sets it,
  // a status read clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (rd_acc)
      ovf_q <= 1'b0;
  end

  // Pointers wrap naturally since
  // DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok)
        wr_ptr_q <= wr_ptr_q
                  + PTR_W'(1);
      if (pop_ok)
        rd_ptr_q <= rd_ptr_q
                  + PTR_W'(1);
    end
  end

  // Occupancy tracks push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      unique case (1'b1)
        push_ok & ~pop_ok:
          cnt_q <= cnt_q + CNT_W'(1);
        ~push_ok & pop_ok:
          cnt_q <= cnt_q - CNT_W'(1);
        default:
          cnt_q <= cnt_q;
      endcase
    end
  end

  syscall_queue_mem #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata ({WB_ADRi, WB_DATi}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign WB_ACKo      = ack_q;
  assign WB_DATo      = dat_q;
  assign SYSCALL_ovf  = ovf_q;
  assign SYSCALL_cnt  = cnt_q;
  assign SYSCALL_trig = ~empty;
  assign SYSCALL_num  = head[W-1:DATA_W];
  assign SYSCALL_info = head[DATA_W-1:0];

endmodule
